// File: rtl/sp_req_router_pkg.sv
// Shared types for the scratchpad request router: bank geometry, the
// per-bank request record and the bank identifier carried by the order FIFO.
package sp_req_router_pkg;

    localparam int NBANKS     = 4;
    localparam int BANK_SEL_W = $clog2(NBANKS);
    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 32;
    localparam int LADDR_W    = ADDR_W - BANK_SEL_W;

    typedef logic [BANK_SEL_W-1:0] bank_id_t;

    typedef struct packed {
        logic               wen;
        logic [LADDR_W-1:0] addr;
        logic [DATA_W-1:0]  wdata;
    } sp_bank_req_t;

endpackage

// File: rtl/sp_req_router_sync_fifo.sv
// Synchronous FIFO with registered storage and no bypass paths.
// Pointers carry one extra wrap bit so full/empty never alias.
module sp_sync_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  T                         din,
    output T                         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    T           mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_push;
    logic        do_pop;

    // Status flags and qualified push/pop; a full FIFO refuses a push even
    // when it pops in the same cycle.
    always_comb begin
        full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        empty   = (wptr == rptr);
        count   = wptr - rptr;
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem[rptr[AW-1:0]];
    end

    // Pointer registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sp_req_router.sv
// Scratchpad front end: decodes the bank from the low address bits, queues
// requests per bank, and returns read data in request order using a FIFO of
// bank ids.
module sp_req_router #(
    parameter int NBANKS    = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int BQ_DEPTH  = 4,
    parameter int ORD_DEPTH = 8
) (
    input  logic                                            CLK,
    input  logic                                            nRST,
    input  logic                                            req_valid,
    output logic                                            req_ready,
    input  logic                                            req_wen,
    input  logic [ADDR_W-1:0]                               req_addr,
    input  logic [DATA_W-1:0]                               req_wdata,
    output logic [NBANKS-1:0]                               bank_req_valid,
    input  logic [NBANKS-1:0]                               bank_req_ready,
    output logic [NBANKS-1:0]                               bank_req_wen,
    output logic [NBANKS-1:0][ADDR_W-$clog2(NBANKS)-1:0]    bank_req_addr,
    output logic [NBANKS-1:0][DATA_W-1:0]                   bank_req_wdata,
    input  logic [NBANKS-1:0]                               bank_rsp_valid,
    input  logic [NBANKS-1:0][DATA_W-1:0]                   bank_rsp_rdata,
    output logic [NBANKS-1:0]                               bank_rsp_ready,
    output logic                                            rsp_valid,
    input  logic                                            rsp_ready,
    output logic [DATA_W-1:0]                               rsp_rdata,
    output logic [$clog2(ORD_DEPTH):0]                      rd_outstanding
);

    import sp_req_router_pkg::*;

    localparam int SEL_W = $clog2(NBANKS);
    localparam int BQ_AW = $clog2(BQ_DEPTH);

    logic [SEL_W-1:0]                 sel;
    logic                             accept;
    sp_bank_req_t                     bq_din;
    sp_bank_req_t                     bq_dout [NBANKS];
    logic [NBANKS-1:0]                bq_push;
    logic [NBANKS-1:0]                bq_pop;
    logic [NBANKS-1:0]                bq_full;
    logic [NBANKS-1:0]                bq_empty;
    logic [NBANKS-1:0][BQ_AW:0]       bq_count_unused;
    logic                             ord_push;
    logic                             ord_pop;
    logic                             ord_full;
    logic                             ord_empty;
    bank_id_t                         ord_head;

    // Request decode and accept: only the addressed bank's FIFO (and, for
    // reads, the order FIFO) can stall the requester.
    always_comb begin
        sel       = req_addr[SEL_W-1:0];
        req_ready = !bq_full[sel] && (req_wen || !ord_full);
        accept    = req_valid && req_ready;
        bq_din    = '{wen: req_wen, addr: req_addr[ADDR_W-1:SEL_W], wdata: req_wdata};
        bq_push   = '0;
        if (accept) bq_push[sel] = 1'b1;
        ord_push  = accept && !req_wen;
    end

    for (genvar i = 0; i < NBANKS; i++) begin : g_bank
        sp_sync_fifo #(
            .DEPTH (BQ_DEPTH),
            .T     (sp_bank_req_t)
        ) u_bq (
            .clk   (CLK),
            .rst_n (nRST),
            .push  (bq_push[i]),
            .pop   (bq_pop[i]),
            .din   (bq_din),
            .dout  (bq_dout[i]),
            .full  (bq_full[i]),
            .empty (bq_empty[i]),
            .count (bq_count_unused[i])
        );

        assign bank_req_valid[i] = !bq_empty[i];
        assign bank_req_wen[i]   = bq_dout[i].wen;
        assign bank_req_addr[i]  = bq_dout[i].addr;
        assign bank_req_wdata[i] = bq_dout[i].wdata;
        assign bq_pop[i]         = !bq_empty[i] && bank_req_ready[i];
    end

    sp_sync_fifo #(
        .DEPTH (ORD_DEPTH),
        .T     (bank_id_t)
    ) u_ord (
        .clk   (CLK),
        .rst_n (nRST),
        .push  (ord_push),
        .pop   (ord_pop),
        .din   (sel),
        .dout  (ord_head),
        .full  (ord_full),
        .empty (ord_empty),
        .count (rd_outstanding)
    );

    // Response mux: only the bank at the head of the order FIFO may hand
    // over data; other banks' responses wait with ready held low.
    always_comb begin
        rsp_valid      = !ord_empty && bank_rsp_valid[ord_head];
        rsp_rdata      = bank_rsp_rdata[ord_head];
        bank_rsp_ready = '0;
        if (rsp_ready && !ord_empty) bank_rsp_ready[ord_head] = 1'b1;
        ord_pop        = rsp_valid && rsp_ready;
    end

endmodule
